// File: rtl/branch_resolve_pkg.sv
// Shared definitions for branch resolution: branch funct3 codes, FSM states, counter reset value
// and the branch-condition helper.
package branch_resolve_pkg;

  localparam logic [2:0] Beq  = 3'b000;
  localparam logic [2:0] Bne  = 3'b001;
  localparam logic [2:0] Blt  = 3'b100;
  localparam logic [2:0] Bge  = 3'b101;
  localparam logic [2:0] Bltu = 3'b110;
  localparam logic [2:0] Bgeu = 3'b111;

  typedef enum logic [1:0] {StIdle, StRedirect, StFlush} state_e;

  localparam logic [1:0] BhtResetVal = 2'b01;

  // Signed and unsigned variants share one lt input; the comparator mode is chosen via br_un.
  function automatic logic branch_cond(logic [2:0] funct3, logic eq, logic lt);
    logic c;
    c = 1'b0;
    case (funct3)
      Beq:        c = eq;
      Bne:        c = ~eq;
      Blt, Bltu:  c = lt;
      Bge, Bgeu:  c = ~lt;
      default:    c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// Fetch redirect handshake: the resolver (master) offers a new PC, fetch (slave) accepts it.
interface branch_resolve_if;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [31:0] redirect_pc;

  modport master (output redirect_valid, output redirect_pc, input redirect_ready);
  modport slave  (input redirect_valid, input redirect_pc, output redirect_ready);
endinterface

// File: rtl/branch_bht.sv
// Branch history table of 2-bit saturating counters; lookups read the pre-update value.
module branch_bht
  import branch_resolve_pkg::*;
#(
  parameter int unsigned ENTRIES = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(ENTRIES)-1:0] lookup_idx,
  output logic                       pred_taken,
  input  logic                       upd_en,
  input  logic [$clog2(ENTRIES)-1:0] upd_idx,
  input  logic                       upd_taken
);

  logic [1:0] table_q [ENTRIES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        table_q[i] <= BhtResetVal;
      end
    end else if (upd_en) begin
      if (upd_taken && table_q[upd_idx] != 2'b11) begin
        table_q[upd_idx] <= table_q[upd_idx] + 2'd1;
      end else if (!upd_taken && table_q[upd_idx] != 2'b00) begin
        table_q[upd_idx] <= table_q[upd_idx] - 2'd1;
      end
    end
  end

  assign pred_taken = table_q[lookup_idx][1];

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolver: detects mispredicts, drives the fetch redirect handshake and
// a flush window, and keeps performance counters. Define BRANCH_PREDICT_EN to build the BHT.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned BHT_ENTRIES  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_is_jal,
  input  logic        ex_is_jalr,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic        br_eq,
  input  logic        br_lt,
  output logic        br_un,
  branch_resolve_if.master redir,
  output logic        flush,
  output logic        ex_stall,
  input  logic [31:0] f_pc,
  output logic        f_pred_taken,
  output logic [31:0] mispredict_cnt,
  output logic [31:0] branch_cnt
);

  localparam logic [2:0] FlushLoad = 3'(FLUSH_CYCLES - 1);

  state_e      state_q;
  logic        redirect_valid_q, flush_q, ex_stall_q;
  logic [31:0] redirect_pc_q, mispredict_cnt_q, branch_cnt_q;
  logic [2:0]  flush_cnt_q;

  logic        cond, taken, is_cf, in_idle, mispredict, br_eval;
  logic [31:0] target;

  assign br_un      = ex_funct3[1];
  assign cond       = branch_cond(ex_funct3, br_eq, br_lt);
  assign taken      = ex_is_jal | ex_is_jalr | (ex_is_branch & cond);
  assign is_cf      = ex_is_branch | ex_is_jal | ex_is_jalr;
  assign in_idle    = (state_q == StIdle);
  assign mispredict = ex_valid & in_idle & is_cf & (taken != ex_pred_taken);
  assign br_eval    = ex_valid & in_idle & ex_is_branch;
  assign target     = taken ? {ex_target[31:1], ex_target[0] & ~ex_is_jalr} : ex_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StIdle;
      redirect_valid_q <= 1'b0;
      flush_q          <= 1'b0;
      ex_stall_q       <= 1'b0;
      redirect_pc_q    <= '0;
      flush_cnt_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mispredict) begin
            state_q          <= StRedirect;
            redirect_valid_q <= 1'b1;
            flush_q          <= 1'b1;
            ex_stall_q       <= 1'b1;
            redirect_pc_q    <= target;
          end
        end
        StRedirect: begin
          if (redir.redirect_ready) begin
            state_q          <= StFlush;
            redirect_valid_q <= 1'b0;
            ex_stall_q       <= 1'b0;
            flush_cnt_q      <= FlushLoad;
          end
        end
        StFlush: begin
          if (flush_cnt_q == 3'd0) begin
            state_q <= StIdle;
            flush_q <= 1'b0;
          end else begin
            flush_cnt_q <= flush_cnt_q - 3'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict_cnt_q <= '0;
      branch_cnt_q     <= '0;
    end else begin
      if (mispredict && mispredict_cnt_q != '1) mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
      if (br_eval && branch_cnt_q != '1)        branch_cnt_q     <= branch_cnt_q + 32'd1;
    end
  end

  assign redir.redirect_valid = redirect_valid_q;
  assign redir.redirect_pc    = redirect_pc_q;
  assign flush                = flush_q;
  assign ex_stall             = ex_stall_q;
  assign mispredict_cnt       = mispredict_cnt_q;
  assign branch_cnt           = branch_cnt_q;

  // Only the index bits of f_pc matter, and none at all in the static-predict build.
  logic unused_f_pc;
  assign unused_f_pc = ^f_pc;

`ifdef BRANCH_PREDICT_EN
  localparam int unsigned IdxW = $clog2(BHT_ENTRIES);

  branch_bht #(
    .ENTRIES(BHT_ENTRIES)
  ) u_bht (
    .clk       (clk),
    .rst       (rst),
    .lookup_idx(f_pc[IdxW+1:2]),
    .pred_taken(f_pred_taken),
    .upd_en    (br_eval),
    .upd_idx   (ex_pc[IdxW+1:2]),
    .upd_taken (cond)
  );
`else
  assign f_pred_taken = 1'b0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: vector table with a scoreboard plus handshake/flush,
// reset-abort and (with BRANCH_PREDICT_EN) prediction-table sequences.
module tb_branch_resolve;
  import branch_resolve_pkg::*;

  localparam int unsigned FC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc, ex_target, f_pc;
  logic        ex_pred_taken, br_eq, br_lt;
  logic        br_un, flush, ex_stall, f_pred_taken;
  logic [31:0] mispredict_cnt, branch_cnt;

  branch_resolve_if rif ();

  branch_resolve #(
    .FLUSH_CYCLES(FC),
    .BHT_ENTRIES (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_is_branch  (ex_is_branch),
    .ex_is_jal     (ex_is_jal),
    .ex_is_jalr    (ex_is_jalr),
    .ex_funct3     (ex_funct3),
    .ex_pc         (ex_pc),
    .ex_target     (ex_target),
    .ex_pred_taken (ex_pred_taken),
    .br_eq         (br_eq),
    .br_lt         (br_lt),
    .br_un         (br_un),
    .redir         (rif),
    .flush         (flush),
    .ex_stall      (ex_stall),
    .f_pc          (f_pc),
    .f_pred_taken  (f_pred_taken),
    .mispredict_cnt(mispredict_cnt),
    .branch_cnt    (branch_cnt)
  );

  always #5 clk = ~clk;

  // cls = {branch, jal, jalr}
  typedef struct {
    logic [2:0]  cls;
    logic [2:0]  f3;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        pred, eq, lt;
    logic        exp_un, exp_rv;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct {
    logic        rv;
    logic [31:0] pc;
  } exp_t;

  vec_t        vecs [11];
  exp_t        sb [$];
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] m_br = 0;
  logic [31:0] m_mp = 0;

  function automatic vec_t mk(logic [2:0] cls, logic [2:0] f3, logic [31:0] pc, logic [31:0] tgt,
                              logic pred, logic eq, logic lt, logic un, logic rv,
                              logic [31:0] epc);
    vec_t v;
    v.cls = cls; v.f3 = f3; v.pc = pc; v.tgt = tgt; v.pred = pred; v.eq = eq; v.lt = lt;
    v.exp_un = un; v.exp_rv = rv; v.exp_pc = epc;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    ex_valid      = 1'b1;
    {ex_is_branch, ex_is_jal, ex_is_jalr} = v.cls;
    ex_funct3     = v.f3;
    ex_pc         = v.pc;
    ex_target     = v.tgt;
    ex_pred_taken = v.pred;
    br_eq         = v.eq;
    br_lt         = v.lt;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    for (k = 0; k < 20; k++) begin
      if (!flush && !rif.redirect_valid) break;
      tick();
    end
    if (k == 20) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: timeout waiting for idle got busy expected idle", nm);
    end
  endtask

  task automatic check_counters(input string nm);
    check({nm, "_branch_cnt"}, branch_cnt, m_br);
    check({nm, "_mispredict_cnt"}, mispredict_cnt, m_mp);
  endtask

  initial begin
    exp_t e;
    vec_t v;
    int   fl;

    vecs[0]  = mk(3'b100, Bgeu,   32'h300,      32'h380, 0, 0, 1, 1, 0, 32'h0);
    vecs[1]  = mk(3'b100, Beq,    32'h100,      32'h140, 0, 1, 0, 0, 1, 32'h140);
    vecs[2]  = mk(3'b100, Bne,    32'hFFFFFFFC, 32'h500, 1, 1, 0, 0, 1, 32'h0);
    vecs[3]  = mk(3'b001, Beq,    32'h1000,     32'h203, 0, 0, 0, 0, 1, 32'h202);
    vecs[4]  = mk(3'b010, Beq,    32'h20,       32'h400, 1, 0, 0, 0, 0, 32'h0);
    vecs[5]  = mk(3'b100, Blt,    32'h40,       32'h80,  1, 0, 1, 0, 0, 32'h0);
    vecs[6]  = mk(3'b100, Bltu,   32'h200,      32'h100, 1, 0, 0, 1, 1, 32'h204);
    vecs[7]  = mk(3'b100, 3'b010, 32'h60,       32'h90,  1, 1, 1, 1, 1, 32'h64);
    vecs[8]  = mk(3'b100, Bge,    32'h70,       32'h10,  0, 0, 0, 0, 1, 32'h10);
    vecs[9]  = mk(3'b000, Beq,    32'h80,       32'h90,  1, 1, 0, 0, 0, 32'h0);
    vecs[10] = mk(3'b010, Beq,    32'h0,        32'h801, 0, 0, 0, 0, 1, 32'h801);

    rst = 1'b1; ex_valid = 1'b0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
    ex_funct3 = 0; ex_pc = 0; ex_target = 0; ex_pred_taken = 0; br_eq = 0; br_lt = 0;
    f_pc = 0; rif.redirect_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_redirect_valid", {31'd0, rif.redirect_valid}, 32'd0);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_ex_stall", {31'd0, ex_stall}, 32'd0);
    check("rst_redirect_pc", rif.redirect_pc, 32'd0);
    check_counters("rst");

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i]);
      e.rv = vecs[i].exp_rv;
      e.pc = vecs[i].exp_pc;
      sb.push_back(e);
      m_br += {31'd0, vecs[i].cls[2]};
      m_mp += {31'd0, vecs[i].exp_rv};
      #1;
      check($sformatf("v%0d_br_un", i), {31'd0, br_un}, {31'd0, vecs[i].exp_un});
      tick();
      ex_valid = 1'b0;
      e = sb.pop_front();
      check($sformatf("v%0d_redirect_valid", i), {31'd0, rif.redirect_valid}, {31'd0, e.rv});
      check($sformatf("v%0d_flush", i), {31'd0, flush}, {31'd0, e.rv});
      check($sformatf("v%0d_ex_stall", i), {31'd0, ex_stall}, {31'd0, e.rv});
      if (e.rv) check($sformatf("v%0d_redirect_pc", i), rif.redirect_pc, e.pc);
      check_counters($sformatf("v%0d", i));
      if (e.rv) begin
        rif.redirect_ready = 1'b1;
        tick();
        rif.redirect_ready = 1'b0;
        wait_idle($sformatf("v%0d_idle", i));
      end
    end

    // Backpressure on the redirect, then a flush window with mispredicting traffic ignored.
    drive(vecs[1]);
    e.rv = 1'b1; e.pc = 32'h140;
    sb.push_back(e);
    m_br += 1; m_mp += 1;
    tick();
    v = mk(3'b010, Beq, 32'h500, 32'h900, 0, 0, 0, 0, 0, 32'h0);
    drive(v);
    e = sb.pop_front();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp%0d_redirect_valid", k), {31'd0, rif.redirect_valid}, {31'd0, e.rv});
      check($sformatf("bp%0d_ex_stall", k), {31'd0, ex_stall}, 32'd1);
      check($sformatf("bp%0d_redirect_pc", k), rif.redirect_pc, e.pc);
      if (k < 2) tick();
    end
    rif.redirect_ready = 1'b1;
    tick();
    rif.redirect_ready = 1'b0;
    fl = 0;
    for (int k = 0; k < 10; k++) begin
      if (!flush) break;
      fl++;
      check($sformatf("fl%0d_redirect_valid", k), {31'd0, rif.redirect_valid}, 32'd0);
      check($sformatf("fl%0d_ex_stall", k), {31'd0, ex_stall}, 32'd0);
      tick();
    end
    ex_valid = 1'b0;
    check("flush_length", fl, FC);
    tick();
    check("post_flush_redirect_valid", {31'd0, rif.redirect_valid}, 32'd0);
    check_counters("post_flush");

    // Reset while a redirect is pending must not complete the handshake.
    drive(vecs[1]);
    tick();
    ex_valid = 1'b0;
    check("abort_pre_redirect_valid", {31'd0, rif.redirect_valid}, 32'd1);
    rst = 1'b1;
    rif.redirect_ready = 1'b1;
    tick();
    rst = 1'b0;
    rif.redirect_ready = 1'b0;
    m_br = 0; m_mp = 0;
    check("abort_redirect_valid", {31'd0, rif.redirect_valid}, 32'd0);
    check("abort_flush", {31'd0, flush}, 32'd0);
    check("abort_ex_stall", {31'd0, ex_stall}, 32'd0);
    check("abort_redirect_pc", rif.redirect_pc, 32'd0);
    check_counters("abort");
    tick();
    check("abort_later_flush", {31'd0, flush}, 32'd0);

`ifdef BRANCH_PREDICT_EN
    f_pc = 32'h10;
    #1;
    check("bht_reset_pred", {31'd0, f_pred_taken}, 32'd0);
    v = mk(3'b100, Beq, 32'h10, 32'h40, 1, 1, 0, 0, 0, 32'h0);
    drive(v);
    tick();
    tick();
    ex_valid = 1'b0;
    check("bht_two_taken_pred", {31'd0, f_pred_taken}, 32'd1);
    f_pc = 32'h14;
    #1;
    check("bht_other_idx_pred", {31'd0, f_pred_taken}, 32'd0);
    f_pc = 32'h10;
    v = mk(3'b100, Beq, 32'h10, 32'h40, 0, 0, 0, 0, 0, 32'h0);
    drive(v);
    tick();
    #1;
    check("bht_same_cycle_pre_update", {31'd0, f_pred_taken}, 32'd1);
    tick();
    ex_valid = 1'b0;
    check("bht_after_two_not_taken", {31'd0, f_pred_taken}, 32'd0);
`else
    f_pc = 32'h10;
    v = mk(3'b100, Beq, 32'h10, 32'h40, 1, 1, 0, 0, 0, 32'h0);
    drive(v);
    tick();
    tick();
    ex_valid = 1'b0;
    check("static_pred", {31'd0, f_pred_taken}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2: number of cycles `flush` stays asserted after a redirect handshake; legal range 1..7.
REQ-002 Parameter BHT_ENTRIES, default 16: prediction-table depth; power of two; used only with BRANCH_PREDICT_EN.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 ex_valid  in  1  instruction in execute is valid.
REQ-006 ex_is_branch / ex_is_jal / ex_is_jalr  in  1 each  instruction class; at most one is set.
REQ-007 ex_funct3  in  3  branch condition field.
REQ-008 ex_pc  in  32  PC of the execute instruction.
REQ-009 ex_target  in  32  ALU-computed branch or jump target.
REQ-010 ex_pred_taken  in  1  prediction made at fetch for this instruction.
REQ-011 br_eq, br_lt  in  1 each  comparator results for the execute operands.
REQ-012 br_un  out  1  unsigned-compare select to the comparator.
REQ-013 redirect_valid  out  1; redirect_ready  in  1; redirect_pc  out  32: fetch redirect handshake.
REQ-014 flush  out  1  squash younger pipeline stages.
REQ-015 ex_stall  out  1  hold the execute stage.
REQ-016 f_pc  in  32; f_pred_taken  out  1: fetch-side prediction lookup.
REQ-017 mispredict_cnt, branch_cnt  out  32 each  performance counters.

Function
REQ-018 br_un = ex_funct3[1], combinational.
REQ-019 Condition: 000 eq; 001 !eq; 100 lt; 101 !lt; 110 lt; 111 !lt; 010/011 not taken.
REQ-020 taken = ex_is_jal | ex_is_jalr | (ex_is_branch & condition).
REQ-021 Mispredict when ex_valid & state==IDLE & (ex_is_branch|ex_is_jal|ex_is_jalr) & (taken != ex_pred_taken).
REQ-022 Redirect target: ex_target when taken (bit 0 forced to 0 for jalr), else ex_pc + 4 with modulo-2^32 wrap.
REQ-023 FSM states IDLE, REDIRECT, FLUSH; reset state IDLE.
REQ-024 IDLE -> REDIRECT on the edge after mispredict; redirect_pc is registered on that edge.
REQ-025 In REDIRECT: redirect_valid=1, flush=1, ex_stall=1; redirect_pc stable until handshake.
REQ-026 REDIRECT -> FLUSH on redirect_valid & redirect_ready; flush counter loads FLUSH_CYCLES-1.
REQ-027 In FLUSH: flush=1, ex_stall=0, redirect_valid=0; counter decrements each cycle; -> IDLE on the edge where the counter is 0.
REQ-028 In IDLE: flush=0, redirect_valid=0, ex_stall=0.
REQ-029 Inputs on ex_* ports are ignored while state != IDLE: no new mispredicts, no counter updates.
REQ-030 branch_cnt increments on each ex_valid conditional branch evaluated in IDLE.
REQ-031 mispredict_cnt increments on each mispredict.
REQ-032 Both counters saturate at 0xFFFFFFFF.

Reset
REQ-033 When rst is high at a clock edge: state=IDLE, redirect_valid=0, flush=0, ex_stall=0, redirect_pc=0, both counters 0, flush counter 0.
REQ-034 Reset asserted mid-REDIRECT or mid-FLUSH aborts the operation, with no handshake completion.

Configuration
REQ-035 With BRANCH_PREDICT_EN defined, a BHT_ENTRIES-entry table of 2-bit saturating counters is built.
REQ-036 The table is indexed by pc[log2(BHT_ENTRIES)+1:2].
REQ-037 f_pred_taken is the counter MSB at index f_pc, combinational.
REQ-038 The table updates only on conditional branches evaluated in IDLE: increment if taken, decrement if not.
REQ-039 On reset, all table entries are 01 (weakly not-taken).
REQ-040 When a table update and a lookup hit the same index in the same cycle, the lookup returns the pre-update value.
REQ-041 Without BRANCH_PREDICT_EN: no table is built; f_pred_taken=0 (static not-taken); all ports remain present.

Structure
REQ-042 A shared package holds: funct3 constants (BEQ..BGEU), FSM state encoding, and the reset value of the 2-bit counter.
REQ-043 One sub-module, branch_bht, holds the prediction table; it is instantiated only under BRANCH_PREDICT_EN.

Verification
REQ-044 BEQ, br_eq=1, pred=0, ex_pc=0x100, target=0x140 -> next cycle redirect_valid=1, redirect_pc=0x140, flush=1, mispredict_cnt=1.
REQ-045 BGEU, br_lt=1, pred=0 -> no redirect, branch_cnt=1, mispredict_cnt=0; br_un=1.
REQ-046 BNE, br_eq=1, pred=1, ex_pc=0xFFFFFFFC -> redirect_pc=0x00000000 (wrap).
REQ-047 redirect_ready held 0 for 3 cycles -> redirect_valid, ex_stall and redirect_pc stable 3 cycles.
REQ-048 redirect_ready held 0 for 3 cycles, then 1 -> flush high exactly FLUSH_CYCLES cycles after handshake; a mispredicting ex_valid during this time is ignored.
REQ-049 JALR, target=0x203, pred=0 -> redirect_pc=0x202.
REQ-050 rst asserted while in REDIRECT -> all outputs 0 next cycle.
REQ-051 With BRANCH_PREDICT_EN: two taken branches at pc 0x10 -> f_pred_taken=1 for f_pc=0x10.
